// File: rtl/mem_stage_pkg.sv
// Shared types and constants for the MEM stage: FSM states, WB control bit
// positions and default widths.
package mem_stage_pkg;

  typedef enum logic {
    IDLE = 1'b0,
    WAIT = 1'b1
  } state_e;

  localparam int WB_REGWRITE = 0;
  localparam int WB_MEMTOREG = 1;

  localparam int DEF_TIMEOUT = 255;
  localparam int DEF_ADDR_W  = 32;
  localparam int DEF_DATA_W  = 32;
  localparam int RD_W        = 5;

endpackage

// File: rtl/mem_wb_reg.sv
// MEM/WB pipeline register: loads when the stage advances, otherwise injects a
// bubble by clearing the write-back controls while holding the datapath fields.
module mem_wb_reg
  import mem_stage_pkg::*;
#(
  parameter int DATA_W = DEF_DATA_W
) (
  input  logic              clk_i,
  input  logic              rst_i,
  input  logic              load_i,
  input  logic [1:0]        wb_i,
  input  logic [RD_W-1:0]   rd_i,
  input  logic [DATA_W-1:0] alu_i,
  input  logic              mem_en_i,
  input  logic [DATA_W-1:0] mem_i,
  output logic              reg_write_o,
  output logic              mem_to_reg_o,
  output logic [RD_W-1:0]   rd_o,
  output logic [DATA_W-1:0] alu_o,
  output logic [DATA_W-1:0] memdata_o
);

  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) begin
      reg_write_o  <= 1'b0;
      mem_to_reg_o <= 1'b0;
      rd_o         <= '0;
      alu_o        <= '0;
      memdata_o    <= '0;
    end else if (load_i) begin
      reg_write_o  <= wb_i[WB_REGWRITE];
      mem_to_reg_o <= wb_i[WB_MEMTOREG];
      rd_o         <= rd_i;
      alu_o        <= alu_i;
      if (mem_en_i) begin
        memdata_o <= mem_i;
      end
    end else begin
      reg_write_o  <= 1'b0;
      mem_to_reg_o <= 1'b0;
    end
  end

endmodule

// File: rtl/mem_access_stage.sv
// MEM pipeline stage: issues one req/ack data-memory access per load/store,
// stalls upstream until it completes (or times out), and feeds WB.
module mem_access_stage
  import mem_stage_pkg::*;
#(
  parameter int TIMEOUT = DEF_TIMEOUT,
  parameter int ADDR_W  = DEF_ADDR_W,
  parameter int DATA_W  = DEF_DATA_W
) (
  input  logic              clk_i,
  input  logic              rst_i,
  input  logic [1:0]        WB_i,
  input  logic              MemRead_i,
  input  logic              MemWrite_i,
  input  logic [RD_W-1:0]   RDaddr_i,
  input  logic [DATA_W-1:0] ALUdata_i,
  input  logic [DATA_W-1:0] data_i,
  output logic              stall_o,
  output logic              mem_req_o,
  output logic              mem_we_o,
  output logic [ADDR_W-1:0] mem_addr_o,
  output logic [DATA_W-1:0] mem_wdata_o,
  input  logic              mem_ack_i,
  input  logic [DATA_W-1:0] mem_rdata_i,
  output logic              RegWrite_o,
  output logic              MemtoReg_o,
  output logic [RD_W-1:0]   RDaddr_o,
  output logic [DATA_W-1:0] ALUdata_o,
  output logic [DATA_W-1:0] memdata_o,
  output logic [DATA_W-1:0] wbdata_o,
  output logic              err_o
);

  localparam int CNT_W = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
  localparam bit TO_EN = (TIMEOUT != 0);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'((TIMEOUT > 0) ? TIMEOUT - 1 : 0);

  state_e           state_q;
  state_e           state_d;
  logic [CNT_W-1:0] cnt_q;
  logic             access;
  logic             done;
  logic             timeout_hit;
  logic             mem_en;
  logic [DATA_W-1:0] mem_val;

  assign access = MemRead_i | MemWrite_i;

  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      IDLE:    if (access) state_d = WAIT;
      WAIT:    if (done)   state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // An ack always wins over the timeout in the same cycle.
  always_comb begin
    timeout_hit = TO_EN && (state_q == WAIT) && (cnt_q == CNT_LAST) && !mem_ack_i;
    done        = (state_q == WAIT) && (mem_ack_i || timeout_hit);
    stall_o     = access && !done;
  end

  // Request and its address/data are captured in IDLE and frozen through WAIT.
  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) begin
      mem_req_o   <= 1'b0;
      mem_we_o    <= 1'b0;
      mem_addr_o  <= '0;
      mem_wdata_o <= '0;
      cnt_q       <= '0;
      err_o       <= 1'b0;
    end else begin
      unique case (state_q)
        IDLE: begin
          if (access) begin
            mem_req_o   <= 1'b1;
            mem_we_o    <= MemWrite_i;
            mem_addr_o  <= ADDR_W'(ALUdata_i);
            mem_wdata_o <= data_i;
            cnt_q       <= '0;
          end
        end
        WAIT: begin
          cnt_q <= cnt_q + CNT_W'(1);
          if (done) begin
            mem_req_o <= 1'b0;
          end
          if (timeout_hit) begin
            err_o <= 1'b1;
          end
        end
        default: ;
      endcase
    end
  end

  assign mem_en  = done && !mem_we_o;
  assign mem_val = timeout_hit ? '0 : mem_rdata_i;

  mem_wb_reg #(
    .DATA_W(DATA_W)
  ) u_mem_wb_reg (
    .clk_i       (clk_i),
    .rst_i       (rst_i),
    .load_i      (!stall_o),
    .wb_i        (WB_i),
    .rd_i        (RDaddr_i),
    .alu_i       (ALUdata_i),
    .mem_en_i    (mem_en),
    .mem_i       (mem_val),
    .reg_write_o (RegWrite_o),
    .mem_to_reg_o(MemtoReg_o),
    .rd_o        (RDaddr_o),
    .alu_o       (ALUdata_o),
    .memdata_o   (memdata_o)
  );

  assign wbdata_o = MemtoReg_o ? memdata_o : ALUdata_o;

endmodule

// File: tb/tb_mem_access_stage.sv
// Randomized bench for mem_access_stage: each instruction is described by its
// kind and memory latency, and expected stalls/outputs follow from those alone.
module tb_mem_access_stage;

  localparam int TO = 4;
  localparam int AW = 32;
  localparam int DW = 32;

  logic          clk_i;
  logic          rst_i;
  logic [1:0]    WB_i;
  logic          MemRead_i;
  logic          MemWrite_i;
  logic [4:0]    RDaddr_i;
  logic [DW-1:0] ALUdata_i;
  logic [DW-1:0] data_i;
  logic          stall_o;
  logic          mem_req_o;
  logic          mem_we_o;
  logic [AW-1:0] mem_addr_o;
  logic [DW-1:0] mem_wdata_o;
  logic          mem_ack_i;
  logic [DW-1:0] mem_rdata_i;
  logic          RegWrite_o;
  logic          MemtoReg_o;
  logic [4:0]    RDaddr_o;
  logic [DW-1:0] ALUdata_o;
  logic [DW-1:0] memdata_o;
  logic [DW-1:0] wbdata_o;
  logic          err_o;

  mem_access_stage #(
    .TIMEOUT(TO),
    .ADDR_W (AW),
    .DATA_W (DW)
  ) dut (
    .clk_i      (clk_i),
    .rst_i      (rst_i),
    .WB_i       (WB_i),
    .MemRead_i  (MemRead_i),
    .MemWrite_i (MemWrite_i),
    .RDaddr_i   (RDaddr_i),
    .ALUdata_i  (ALUdata_i),
    .data_i     (data_i),
    .stall_o    (stall_o),
    .mem_req_o  (mem_req_o),
    .mem_we_o   (mem_we_o),
    .mem_addr_o (mem_addr_o),
    .mem_wdata_o(mem_wdata_o),
    .mem_ack_i  (mem_ack_i),
    .mem_rdata_i(mem_rdata_i),
    .RegWrite_o (RegWrite_o),
    .MemtoReg_o (MemtoReg_o),
    .RDaddr_o   (RDaddr_o),
    .ALUdata_o  (ALUdata_o),
    .memdata_o  (memdata_o),
    .wbdata_o   (wbdata_o),
    .err_o      (err_o)
  );

  initial clk_i = 1'b0;
  always #5 clk_i = ~clk_i;

  int            n_tests = 0;
  int            n_fail  = 0;
  logic [DW-1:0] exp_mem = '0;
  logic          exp_err = 1'b0;

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
    end
  endtask

  task automatic check_all_zero(input string tag);
    chk({tag, "_req"},   mem_req_o,   0);
    chk({tag, "_we"},    mem_we_o,    0);
    chk({tag, "_addr"},  mem_addr_o,  0);
    chk({tag, "_wdata"}, mem_wdata_o, 0);
    chk({tag, "_rw"},    RegWrite_o,  0);
    chk({tag, "_m2r"},   MemtoReg_o,  0);
    chk({tag, "_rd"},    RDaddr_o,    0);
    chk({tag, "_alu"},   ALUdata_o,   0);
    chk({tag, "_mem"},   memdata_o,   0);
    chk({tag, "_err"},   err_o,       0);
  endtask

  // Called just after a posedge; returns just after the posedge that retires it.
  // ack_at = WAIT cycle (1-based) carrying the ack; 0 or > TO means no ack.
  task automatic run_instr(input logic rd_en, input logic wr_en, input logic [1:0] wb,
                           input logic [4:0] rd, input logic [DW-1:0] alu,
                           input logic [DW-1:0] wdata, input int ack_at,
                           input logic [DW-1:0] rdata, input bit spurious);
    bit is_mem;
    bit is_load;
    bit tmo;
    int nstall;
    is_mem  = rd_en | wr_en;
    is_load = rd_en & ~wr_en;
    tmo     = is_mem && (ack_at < 1 || ack_at > TO);
    nstall  = !is_mem ? 0 : (tmo ? TO : ack_at);

    WB_i       = wb;
    MemRead_i  = rd_en;
    MemWrite_i = wr_en;
    RDaddr_i   = rd;
    ALUdata_i  = alu;
    data_i     = wdata;

    for (int c = 0; c <= TO + 1; c++) begin
      mem_ack_i   = (c == 0) ? spurious : (is_mem && c == ack_at);
      mem_rdata_i = (mem_ack_i && c != 0) ? rdata : $urandom;
      @(negedge clk_i);
      chk("stall", stall_o, (c < nstall));
      if (c == 0) begin
        chk("req_idle", mem_req_o, 0);
      end else begin
        chk("req_wait", mem_req_o, 1);
        chk("we", mem_we_o, wr_en);
        chk("addr", mem_addr_o, alu);
        if (wr_en) chk("wdata", mem_wdata_o, wdata);
        chk("bubble", RegWrite_o, 0);
      end
      @(posedge clk_i);
      #1;
      if (c >= nstall) break;
    end
    mem_ack_i = 1'b0;

    if (is_load) exp_mem = tmo ? '0 : rdata;
    if (tmo) exp_err = 1'b1;

    chk("regwrite", RegWrite_o, wb[0]);
    chk("memtoreg", MemtoReg_o, wb[1]);
    chk("rdaddr", RDaddr_o, rd);
    chk("aludata", ALUdata_o, alu);
    chk("memdata", memdata_o, exp_mem);
    chk("wbdata", wbdata_o, wb[1] ? exp_mem : alu);
    chk("err", err_o, exp_err);
    chk("req_released", mem_req_o, 0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  initial begin
    rst_i       = 1'b0;
    WB_i        = '0;
    MemRead_i   = 1'b0;
    MemWrite_i  = 1'b0;
    RDaddr_i    = '0;
    ALUdata_i   = '0;
    data_i      = '0;
    mem_ack_i   = 1'b0;
    mem_rdata_i = '0;
    #12;
    check_all_zero("reset");
    chk("reset_stall", stall_o, 0);
    rst_i = 1'b1;
    @(posedge clk_i);
    #1;

    run_instr(1'b0, 1'b0, 2'b01, 5'd5, 32'h1234, 32'h0, 0, 32'h0, 1'b0);
    run_instr(1'b1, 1'b0, 2'b11, 5'd7, 32'h40, 32'h0, 3, 32'hDEADBEEF, 1'b0);
    run_instr(1'b0, 1'b1, 2'b00, 5'd3, 32'h80, 32'hA5A5A5A5, 1, 32'h0, 1'b0);
    run_instr(1'b0, 1'b1, 2'b01, 5'd4, 32'h84, 32'h11112222, 1, 32'h0, 1'b1);
    run_instr(1'b1, 1'b0, 2'b11, 5'd9, 32'h100, 32'h0, 0, 32'h0, 1'b0);
    run_instr(1'b1, 1'b1, 2'b00, 5'd2, 32'h200, 32'hCAFEF00D, 2, 32'h0, 1'b0);
    run_instr(1'b1, 1'b0, 2'b11, 5'd6, 32'h204, 32'h0, 1, 32'h600DC0DE, 1'b0);
    run_instr(1'b1, 1'b0, 2'b11, 5'd8, 32'h208, 32'h0, TO, 32'h13579BDF, 1'b1);
    run_instr(1'b0, 1'b0, 2'b01, 5'd1, 32'hFFFFFFFF, 32'h0, 0, 32'h0, 1'b1);

    // Reset in the middle of an outstanding load
    WB_i      = 2'b11;
    MemRead_i = 1'b1;
    RDaddr_i  = 5'd12;
    ALUdata_i = 32'h300;
    @(posedge clk_i);
    #1;
    @(posedge clk_i);
    #1;
    chk("midwait_req", mem_req_o, 1);
    rst_i     = 1'b0;
    MemRead_i = 1'b0;
    WB_i      = '0;
    #1;
    check_all_zero("midwait_reset");
    chk("midwait_stall", stall_o, 0);
    exp_mem = '0;
    exp_err = 1'b0;
    #2;
    rst_i = 1'b1;
    @(posedge clk_i);
    #1;
    run_instr(1'b0, 1'b0, 2'b01, 5'd10, 32'hABCD, 32'h0, 0, 32'h0, 1'b0);
    run_instr(1'b1, 1'b0, 2'b11, 5'd11, 32'h44, 32'h0, 1, 32'h0BADF00D, 1'b0);

    for (int i = 0; i < 300; i++) begin
      int op;
      op = $urandom_range(0, 3);
      run_instr(op == 1 || op == 3, op == 2 || op == 3, 2'($urandom), 5'($urandom),
                $urandom, $urandom, $urandom_range(0, TO + 1), $urandom,
                ($urandom_range(0, 3) == 0));
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
